// File: rtl/pos_sweep_checker.sv
// pos_sweep_checker: exhaustive stimulus-and-check sweep that drives every
// input vector onto a canonical PoS function and its minimized form.
//
// Ports:
//   clk, rst_n         rising-edge clock, async active-low reset
//   start              sweep request, only honoured in IDLE
//   ref_s, dut_s       canonical / minimized function outputs
//   vec                current input vector {x,y,z}
//   busy, done, pass   sweep status (done is a one-cycle pulse)
//   ref_table          captured ref_s, bit k = value at vector k
//   mism_mask          bit k set when ref_s != dut_s at vector k
//   mism_count         number of set bits in mism_mask
//   first_fail         lowest failing vector, 0 when none failed
`timescale 1ns/1ps

module pos_sweep_checker #(
   parameter int N_IN   = 3,
   parameter int SETTLE = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 ref_s,
   input  logic                 dut_s,
   output logic [N_IN-1:0]      vec,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [2**N_IN-1:0]   ref_table,
   output logic [2**N_IN-1:0]   mism_mask,
   output logic [N_IN:0]        mism_count,
   output logic [N_IN-1:0]      first_fail
);

   localparam int NV = 2**N_IN;
   localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   localparam logic [CW-1:0]   CNT_LAST = CW'(SETTLE - 1);
   localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
   localparam logic [N_IN-1:0] VEC_LAST = {N_IN{1'b1}};
   localparam logic [N_IN-1:0] VEC_ONE  = N_IN'(1);
   localparam logic [N_IN:0]   MC_ONE   = (N_IN+1)'(1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DRIVE,
      S_SAMPLE,
      S_DONE
   } state_t;

   state_t            state_q;
   logic [CW-1:0]     cnt_q;
   logic [N_IN-1:0]   vec_q;
   logic              busy_q;
   logic              done_q;
   logic              pass_q;
   logic [NV-1:0]     table_q;
   logic [NV-1:0]     mask_q;
   logic [N_IN:0]     mcount_q;
   logic [N_IN-1:0]   ffail_q;

   logic mism;

   assign mism = ref_s ^ dut_s;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         vec_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         pass_q   <= 1'b0;
         table_q  <= '0;
         mask_q   <= '0;
         mcount_q <= '0;
         ffail_q  <= '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               vec_q  <= '0;
               done_q <= 1'b0;
               if (start) begin
                  table_q  <= '0;
                  mask_q   <= '0;
                  mcount_q <= '0;
                  ffail_q  <= '0;
                  pass_q   <= 1'b0;
                  cnt_q    <= '0;
                  busy_q   <= 1'b1;
                  state_q  <= S_DRIVE;
               end
            end

            S_DRIVE: begin
               if (cnt_q == CNT_LAST) begin
                  state_q <= S_SAMPLE;
               end else begin
                  cnt_q <= cnt_q + CNT_ONE;
               end
            end

            S_SAMPLE: begin
               table_q[vec_q] <= ref_s;
               mask_q[vec_q]  <= mism;
               if (mism) begin
                  mcount_q <= mcount_q + MC_ONE;
                  // An empty count means no earlier vector failed.
                  if (mcount_q == '0) begin
                     ffail_q <= vec_q;
                  end
               end
               if (vec_q == VEC_LAST) begin
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end else begin
                  vec_q   <= vec_q + VEC_ONE;
                  cnt_q   <= '0;
                  state_q <= S_DRIVE;
               end
            end

            S_DONE: begin
               // start is ignored here; IDLE picks it up next edge.
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               pass_q  <= (mcount_q == '0);
               vec_q   <= '0;
               state_q <= S_IDLE;
            end

            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign vec        = vec_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign pass       = pass_q;
   assign ref_table  = table_q;
   assign mism_mask  = mask_q;
   assign mism_count = mcount_q;
   assign first_fail = ffail_q;

endmodule

// File: tb/tb_pos_sweep_checker.sv
// Bench for pos_sweep_checker: two instances (SETTLE=1 and SETTLE=3)
// driven by PoS function models, results checked through a scoreboard.
`timescale 1ns/1ps

module tb_pos_sweep_checker;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;
   logic start1, start3;
   int   mode1, mode3;

   logic [2:0] vec1, vec3;
   logic       ref1, dut1, ref3, dut3;
   logic       busy1, done1, pass1, busy3, done3, pass3;
   logic [7:0] tbl1, mask1, tbl3, mask3;
   logic [3:0] cnt1, cnt3;
   logic [2:0] ff1, ff3;

   // Mode 0: PoS(1,5,7) vs (Y+Z')(X'+Z')
   // Mode 1: PoS(1,5,7) vs constant 1
   // Mode 2: PoS(0,2,4,7) vs (Y+Z)(X+Z)(X'+Y'+Z')
   function automatic logic f_ref(int m, logic [2:0] v);
      logic x, y, z;
      x = v[2]; y = v[1]; z = v[0];
      if (m == 2)
         return (x|y|z) & (x|~y|z) & (~x|y|z) & (~x|~y|~z);
      return (x|y|~z) & (~x|y|~z) & (~x|~y|~z);
   endfunction

   function automatic logic f_dut(int m, logic [2:0] v);
      logic x, y, z;
      x = v[2]; y = v[1]; z = v[0];
      if (m == 1) return 1'b1;
      if (m == 2) return (y|z) & (x|z) & (~x|~y|~z);
      return (y|~z) & (~x|~z);
   endfunction

   assign ref1 = f_ref(mode1, vec1);
   assign dut1 = f_dut(mode1, vec1);
   assign ref3 = f_ref(mode3, vec3);
   assign dut3 = f_dut(mode3, vec3);

   pos_sweep_checker #(.N_IN(3), .SETTLE(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1),
      .ref_s(ref1), .dut_s(dut1), .vec(vec1),
      .busy(busy1), .done(done1), .pass(pass1),
      .ref_table(tbl1), .mism_mask(mask1),
      .mism_count(cnt1), .first_fail(ff1)
   );

   pos_sweep_checker #(.N_IN(3), .SETTLE(3)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .start(start3),
      .ref_s(ref3), .dut_s(dut3), .vec(vec3),
      .busy(busy3), .done(done3), .pass(pass3),
      .ref_table(tbl3), .mism_mask(mask3),
      .mism_count(cnt3), .first_fail(ff3)
   );

   typedef struct {
      logic [7:0] tbl;
      logic [7:0] mask;
      logic [3:0] cnt;
      logic [2:0] ff;
      logic       pass;
      int         done_at;
   } exp_t;

   exp_t q1[$];
   exp_t q3[$];

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   function automatic exp_t mk(logic [7:0] t, logic [7:0] m,
                               logic [3:0] c, logic [2:0] f,
                               logic p, int d);
      exp_t e;
      e.tbl = t; e.mask = m; e.cnt = c; e.ff = f;
      e.pass = p; e.done_at = d;
      return e;
   endfunction

   // Scoreboard monitor, SETTLE=1 instance
   initial begin : mon1
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && done1) begin
            if (q1.size() == 0) begin
               n_chk++;
               $display("FAIL dut1 done: got unexpected pulse at cycle %0d", cyc);
            end else begin
               e = q1.pop_front();
               chk("dut1 done cycle", cyc, e.done_at);
               chk("dut1 ref_table", tbl1, e.tbl);
               chk("dut1 mism_mask", mask1, e.mask);
               chk("dut1 mism_count", cnt1, e.cnt);
               chk("dut1 first_fail", ff1, e.ff);
               @(posedge clk); #1;
               chk("dut1 pass", pass1, e.pass);
               chk("dut1 busy after done", busy1, 0);
               chk("dut1 done width", done1, 0);
            end
         end
      end
   end

   // Scoreboard monitor, SETTLE=3 instance
   initial begin : mon3
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && done3) begin
            if (q3.size() == 0) begin
               n_chk++;
               $display("FAIL dut3 done: got unexpected pulse at cycle %0d", cyc);
            end else begin
               e = q3.pop_front();
               chk("dut3 done cycle", cyc, e.done_at);
               chk("dut3 ref_table", tbl3, e.tbl);
               chk("dut3 mism_mask", mask3, e.mask);
               chk("dut3 mism_count", cnt3, e.cnt);
               chk("dut3 first_fail", ff3, e.ff);
               @(posedge clk); #1;
               chk("dut3 pass", pass3, e.pass);
               chk("dut3 busy after done", busy3, 0);
               chk("dut3 done width", done3, 0);
            end
         end
      end
   end

   task automatic accept1(output int e0);
      @(negedge clk);
      start1 = 1'b1;
      @(posedge clk); #1;
      e0 = cyc;
      start1 = 1'b0;
   endtask

   task automatic accept3(output int e0);
      @(negedge clk);
      start3 = 1'b1;
      @(posedge clk); #1;
      e0 = cyc;
      start3 = 1'b0;
   endtask

   task automatic wait_idle1();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (q1.size() == 0 && !busy1) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         n_chk++;
         $display("FAIL dut1 timeout: got busy=%0d pending=%0d required idle",
                  busy1, q1.size());
      end
   endtask

   task automatic wait_idle3();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (q3.size() == 0 && !busy3) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         n_chk++;
         $display("FAIL dut3 timeout: got busy=%0d pending=%0d required idle",
                  busy3, q3.size());
      end
   endtask

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int e0;
      rst_n  = 1'b0;
      start1 = 1'b0;
      start3 = 1'b0;
      mode1  = 0;
      mode3  = 1;
      repeat (3) @(negedge clk);

      // Reset state
      chk("reset vec", vec1, 0);
      chk("reset busy", busy1, 0);
      chk("reset done", done1, 0);
      chk("reset pass", pass1, 0);
      chk("reset ref_table", tbl1, 0);
      chk("reset mism_mask", mask1, 0);
      chk("reset mism_count", cnt1, 0);
      chk("reset first_fail", ff1, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Equivalent pair
      mode1 = 0;
      accept1(e0);
      q1.push_back(mk(8'h5D, 8'h00, 4'd0, 3'd0, 1'b1, e0 + 16));
      chk("busy after start", busy1, 1);
      wait_idle1();

      // Broken minimization
      mode1 = 1;
      accept1(e0);
      q1.push_back(mk(8'h5D, 8'hA2, 4'd3, 3'd1, 1'b0, e0 + 16));
      wait_idle1();

      // Truth-table capture
      mode1 = 2;
      accept1(e0);
      q1.push_back(mk(8'h6A, 8'h00, 4'd0, 3'd0, 1'b1, e0 + 16));
      wait_idle1();

      // Settle timing, SETTLE=3
      mode3 = 1;
      accept3(e0);
      q3.push_back(mk(8'h5D, 8'hA2, 4'd3, 3'd1, 1'b0, e0 + 32));
      for (int k = 0; k < 8; k++) begin
         chk("dut3 vec start", vec3, 32'(k));
         repeat (3) @(posedge clk);
         #1;
         chk("dut3 vec end", vec3, 32'(k));
         @(posedge clk); #1;
      end
      wait_idle3();

      // start re-pulsed mid-sweep is ignored
      mode1 = 0;
      accept1(e0);
      q1.push_back(mk(8'h5D, 8'h00, 4'd0, 3'd0, 1'b1, e0 + 16));
      while (cyc < e0 + 4) @(negedge clk);
      start1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0;
      chk("ignored start vec", vec1, 2);
      chk("ignored start busy", busy1, 1);
      wait_idle1();

      // Reset mid-sweep
      mode1 = 1;
      accept1(e0);
      repeat (9) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("midreset vec", vec1, 0);
      chk("midreset busy", busy1, 0);
      chk("midreset done", done1, 0);
      chk("midreset pass", pass1, 0);
      chk("midreset ref_table", tbl1, 0);
      chk("midreset mism_mask", mask1, 0);
      chk("midreset mism_count", cnt1, 0);
      chk("midreset first_fail", ff1, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      chk("post-reset idle busy", busy1, 0);
      chk("post-reset idle vec", vec1, 0);

      // Back-to-back sweeps with start held
      mode1 = 1;
      @(negedge clk);
      start1 = 1'b1;
      @(posedge clk); #1;
      e0 = cyc;
      q1.push_back(mk(8'h5D, 8'hA2, 4'd3, 3'd1, 1'b0, e0 + 16));
      q1.push_back(mk(8'h5D, 8'hA2, 4'd3, 3'd1, 1'b0, e0 + 34));
      repeat (18) @(posedge clk);
      #1;
      chk("b2b restart busy", busy1, 1);
      chk("b2b clear ref_table", tbl1, 0);
      chk("b2b clear mism_mask", mask1, 0);
      chk("b2b clear mism_count", cnt1, 0);
      chk("b2b clear first_fail", ff1, 0);
      @(negedge clk);
      start1 = 1'b0;
      wait_idle1();
      wait_idle3();

      chk("dut1 queue drained", q1.size(), 0);
      chk("dut3 queue drained", q3.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
